mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the single-port byte-lane memory `mem`. It shares `mem` between the instruction-fetch port and the load/store port. It converts load/store size into per-lane active-low write enables and formats load data with zero or sign extension. One request is granted per cycle, and its response returns exactly one cycle later, matching the memory's registered read.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width; matches `mem`.
- `DATA_WIDTH_BYTES`, 4: number of memory byte lanes; must be 4.

Ports:
- `clk` in 1: clock.
- `rstL` in 1: reset, synchronous, active-low.
- `if_req_valid` in 1: fetch request.
- `if_req_ready` out 1: fetch request granted this cycle.
- `if_addr` in `ADDR_WIDTH`: fetch byte address.
- `if_rsp_valid` out 1: fetch data valid.
- `if_rsp_data` out 32: fetched word; lane 0 is bits [7:0].
- `ls_req_valid` in 1: load/store request.
- `ls_req_ready` out 1: load/store request granted this cycle.
- `ls_addr` in `ADDR_WIDTH`: load/store byte address.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `ls_signed` in 1: sign-extend load data.
- `ls_wdata` in 32: store data, low bytes first.
- `ls_rsp_valid` out 1: load/store response valid.
- `ls_rsp_data` out 32: formatted load data; 0 for stores and errors.
- `ls_rsp_err` out 1: illegal size; qualified by `ls_rsp_valid`.
- `mem_wenableL` out [`DATA_WIDTH_BYTES`] x 1: per-lane active-low write enable to `mem`.
- `mem_data_w` out [`DATA_WIDTH_BYTES`] x 8: write data to `mem`.
- `mem_addr` out `ADDR_WIDTH`: address to `mem`.
- `mem_data_r` in [`DATA_WIDTH_BYTES`] x 8: registered read data from `mem`.

## Operation
- **Handshake:** a request transfers when `*_req_valid` and `*_req_ready` are both high at a rising edge. `*_req_ready` is combinational from the valids and the arbitration state, and is 0 while `rstL` is 0. At most one ready is high per cycle.
- **Responses:** no response backpressure. Requesters must accept the response in the cycle it is presented.
- **Memory drive:**
  - Granted requester drives `mem_addr` combinationally in the grant cycle.
  - When nothing is granted: `mem_addr` = 0 and all `mem_wenableL` = 1.
- **Lane enables:** for a granted store, `mem_wenableL[i]` = 0 for i < 2^`ls_size`, else 1. `mem_data_w[i]` = `ls_wdata[8i+7:8i]`. Fetches and loads keep all enables at 1.
- **Misaligned addresses:** permitted. Lane i maps to `addr + i`.
- **Illegal size (`ls_size` = 3):**
  - The request is still accepted.
  - No memory write occurs (all enables 1).
  - The response carries `ls_rsp_err` = 1 and data 0.
- **Response tracking:** owner register `rsp_owner` ∈ {NONE, IF, LS}, plus registered copies of `ls_size`, `ls_signed`, `ls_we` and error. Next cycle:
  - IF: `if_rsp_data` = {`mem_data_r[3]`..`mem_data_r[0]`}.
  - LS load: lanes at or above 2^size are replaced by extension bits, which are the MSB of the top valid lane when `ls_signed`, else 0.
  - LS store: data 0, matching the memory returning 0 on written lanes.
- **Arbitration, default:** fixed priority, LS over IF. Fetch is starved while LS requests back-to-back.
- **Response ordering:** responses in a cycle belong only to the previous cycle's grant.
- **Mid-operation reset:** `rstL` low drops the pending owner to NONE. No response is emitted for a request granted in the cycle before reset.

## Timing
- Latency: grant at edge N → `*_rsp_valid` high during cycle N+1, for exactly one cycle.
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses.
- Reset values (registered, after an edge with `rstL` = 0):
  - `if_rsp_valid` = 0, `ls_rsp_valid` = 0, `ls_rsp_err` = 0.
  - `if_rsp_data` = 0, `ls_rsp_data` = 0.
  - `rsp_owner` = NONE; round-robin pointer = IF-last.
- While `rstL` = 0: `mem_wenableL` all 1, `mem_addr` = 0.
- Simultaneous valids resolve in the same cycle, with no bubble.

## Configuration
- `MEM_ARB_RR_EN` defined: two-way round-robin. A 1-bit `last_grant` register updates on every grant. When both requesters are valid, the one not granted last wins, so no starvation beyond one cycle.
- `MEM_ARB_RR_EN` undefined: fixed LS-over-IF priority as above; `last_grant` is not instantiated.

## Structure
- Package `mem_pkg`:
  - `ADDR_WIDTH`, `DATA_WIDTH_BYTES`, `MEM_SIZE_BYTES`.
  - enum `mem_size_t` (BYTE, HALF, WORD, ILLEGAL).
  - enum `mem_owner_t` (NONE, IF, LS).
- Sub-module `mem_load_fmt`: combinational lane masking and sign/zero extension from the registered size/signed fields.

## Test plan
- **Store word then load:** after reset, LS store word 0xDEADBEEF at addr 8, then LS load word at 8. Load response in the cycle after its grant = 0xDEADBEEF; store response data 0, err 0.
- **Signed byte load:** load byte signed at addr 11 (0xDE) → `ls_rsp_data` = 0xFFFFFFDE. Unsigned → 0x000000DE. Half signed at 10 → 0xFFFFDEAD.
- **Contention:** both valid for 4 cycles.
  - Without the macro: LS granted 4 times, IF 0.
  - With `MEM_ARB_RR_EN`: grants alternate, LS first after reset (IF-last).
- **Illegal size:** store with `ls_size` = 3 at addr 0 with data 0x12345678. `ls_rsp_err` = 1 next cycle, and a later word load at 0 returns 0.
- **Reset mid-operation:** `rstL` low the cycle after an IF grant → no `if_rsp_valid`, `mem_wenableL` all 1, readies 0.
- **Misaligned store:** store half 0xABCD at addr 5 → lanes 0–1 enabled. A word load at 4 returns 0x00ABCD00.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, size/owner enums and lane helper for mem_arbiter.
// MEM_ARB_RR_EN (optional) turns fixed priority into two-way round-robin.
package mem_pkg;

   localparam int ADDR_WIDTH       = 32;
   localparam int DATA_WIDTH_BYTES = 4;
   localparam int MEM_SIZE_BYTES   = 1024;

   typedef enum logic [1:0] {
      BYTE    = 2'd0,
      HALF    = 2'd1,
      WORD    = 2'd2,
      ILLEGAL = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      LS   = 2'd2
   } mem_owner_t;

   // Lanes touched by an access of the given size, lane 0 first
   function automatic logic [3:0] lane_mask(input mem_size_t sz);
      logic [3:0] m;
      m = 4'b0000;
      unique case (sz)
         BYTE:    m = 4'b0001;
         HALF:    m = 4'b0011;
         WORD:    m = 4'b1111;
         ILLEGAL: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// mem_load_fmt: masks unused lanes of a load and applies sign/zero
// extension; stores and illegal sizes return zero.
module mem_load_fmt (
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        sign_en,
   input  logic        store,
   input  logic        err,
   output logic [31:0] data
);

   import mem_pkg::*;

   logic ext;

   // Keep valid lanes, fill the rest with the extension bit
   always_comb begin
      ext  = 1'b0;
      data = '0;
      unique case (mem_size_t'(size))
         BYTE: begin
            ext  = sign_en & raw[7];
            data = {{24{ext}}, raw[7:0]};
         end
         HALF: begin
            ext  = sign_en & raw[15];
            data = {{16{ext}}, raw[15:0]};
         end
         WORD:    data = raw;
         ILLEGAL: data = '0;
      endcase
      if (store || err) data = '0;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-lane memory between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin; default is LS-over-IF priority.
module mem_arbiter #(
   parameter int ADDR_WIDTH       = mem_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH_BYTES = mem_pkg::DATA_WIDTH_BYTES
) (
   input  logic                             clk,
   input  logic                             rstL,
   input  logic                             if_req_valid,
   output logic                             if_req_ready,
   input  logic [ADDR_WIDTH-1:0]            if_addr,
   output logic                             if_rsp_valid,
   output logic [31:0]                      if_rsp_data,
   input  logic                             ls_req_valid,
   output logic                             ls_req_ready,
   input  logic [ADDR_WIDTH-1:0]            ls_addr,
   input  logic                             ls_we,
   input  logic [1:0]                       ls_size,
   input  logic                             ls_signed,
   input  logic [31:0]                      ls_wdata,
   output logic                             ls_rsp_valid,
   output logic [31:0]                      ls_rsp_data,
   output logic                             ls_rsp_err,
   output logic [DATA_WIDTH_BYTES-1:0]      mem_wenableL,
   output logic [DATA_WIDTH_BYTES-1:0][7:0] mem_data_w,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic [DATA_WIDTH_BYTES-1:0][7:0] mem_data_r
);

   import mem_pkg::*;

   logic        grant_if;
   logic        grant_ls;
   mem_size_t   req_size;
   mem_owner_t  rsp_owner;
   mem_size_t   r_size;
   logic        r_signed;
   logic        r_we;
   logic        r_err;
   logic [31:0] ls_fmt;

`ifdef MEM_ARB_RR_EN
   logic last_grant;
`endif

   assign req_size = mem_size_t'(ls_size);

   // Pick at most one requester this cycle, nothing while in reset
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (rstL) begin
`ifdef MEM_ARB_RR_EN
         if (ls_req_valid && if_req_valid) begin
            grant_ls = !last_grant;
            grant_if = last_grant;
         end else begin
            grant_ls = ls_req_valid;
            grant_if = if_req_valid;
         end
`else
         grant_ls = ls_req_valid;
         grant_if = if_req_valid && !ls_req_valid;
`endif
      end
   end

   assign if_req_ready = grant_if;
   assign ls_req_ready = grant_ls;

   // Steer the granted request onto the memory port
   always_comb begin
      mem_addr     = '0;
      mem_wenableL = '1;
      unique case (1'b1)
         grant_ls: begin
            mem_addr = ls_addr;
            if (ls_we) mem_wenableL = ~lane_mask(req_size);
         end
         grant_if: mem_addr = if_addr;
         default: ;
      endcase
   end

   assign mem_data_w = ls_wdata;

   // Record who owns next cycle's response and how to format it
   always_ff @(posedge clk) begin
      if (!rstL) begin
         rsp_owner <= NONE;
         r_size    <= BYTE;
         r_signed  <= 1'b0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         unique case (1'b1)
            grant_ls: rsp_owner <= LS;
            grant_if: rsp_owner <= IF;
            default:  rsp_owner <= NONE;
         endcase
         if (grant_ls) begin
            r_size   <= req_size;
            r_signed <= ls_signed;
            r_we     <= ls_we;
            r_err    <= (req_size == ILLEGAL);
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember the last winner; 1 means LS, reset leaves IF as last
   always_ff @(posedge clk) begin
      if (!rstL)
         last_grant <= 1'b0;
      else if (grant_ls || grant_if)
         last_grant <= grant_ls;
   end
`endif

   mem_load_fmt u_fmt (
      .raw     (mem_data_r),
      .size    (r_size),
      .sign_en (r_signed),
      .store   (r_we),
      .err     (r_err),
      .data    (ls_fmt)
   );

   // A response granted just before reset is dropped while rstL is low
   assign if_rsp_valid = rstL && (rsp_owner == IF);
   assign ls_rsp_valid = rstL && (rsp_owner == LS);
   assign ls_rsp_err   = ls_rsp_valid && r_err;
   assign if_rsp_data  = if_rsp_valid ? 32'(mem_data_r) : '0;
   assign ls_rsp_data  = ls_rsp_valid ? ls_fmt : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// byte-array model of memory contents and the arbitration rules.
module tb_mem_arbiter;

   localparam int MEMN = mem_pkg::MEM_SIZE_BYTES;

   logic              clk;
   logic              rstL;
   logic              if_req_valid;
   logic              if_req_ready;
   logic [31:0]       if_addr;
   logic              if_rsp_valid;
   logic [31:0]       if_rsp_data;
   logic              ls_req_valid;
   logic              ls_req_ready;
   logic [31:0]       ls_addr;
   logic              ls_we;
   logic [1:0]        ls_size;
   logic              ls_signed;
   logic [31:0]       ls_wdata;
   logic              ls_rsp_valid;
   logic [31:0]       ls_rsp_data;
   logic              ls_rsp_err;
   logic [3:0]        mem_wenableL;
   logic [3:0][7:0]   mem_data_w;
   logic [31:0]       mem_addr;
   logic [3:0][7:0]   mem_data_r;

   mem_arbiter dut (
      .clk          (clk),
      .rstL         (rstL),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_addr      (if_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .ls_req_valid (ls_req_valid),
      .ls_req_ready (ls_req_ready),
      .ls_addr      (ls_addr),
      .ls_we        (ls_we),
      .ls_size      (ls_size),
      .ls_signed    (ls_signed),
      .ls_wdata     (ls_wdata),
      .ls_rsp_valid (ls_rsp_valid),
      .ls_rsp_data  (ls_rsp_data),
      .ls_rsp_err   (ls_rsp_err),
      .mem_wenableL (mem_wenableL),
      .mem_data_w   (mem_data_w),
      .mem_addr     (mem_addr),
      .mem_data_r   (mem_data_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory seen by the DUT: registered read, written lanes read back 0
   logic [7:0] env_mem [MEMN];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         int unsigned ea;
         ea = (mem_addr + 32'(i)) % 32'(MEMN);
         if (!mem_wenableL[i]) begin
            env_mem[ea]   <= mem_data_w[i];
            mem_data_r[i] <= 8'h00;
         end else begin
            mem_data_r[i] <= env_mem[ea];
         end
      end
   end

   // Reference contents, updated per accepted store transaction
   logic [7:0]  ref_mem [MEMN];
   logic        exp_if_v, exp_ls_v, exp_ls_e;
   logic [31:0] exp_if_d, exp_ls_d;
   logic        last_ls;
   logic        dir_on, dir_e;
   logic [31:0] dir_d;
   int          n_vec, n_err;
   int          obs_ls, obs_if;
   logic        first_ls, first_seen;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++)
         w[8*i +: 8] = ref_mem[(a + 32'(i)) % 32'(MEMN)];
      return w;
   endfunction

   function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                            input int sz,
                                            input logic sg);
      longint unsigned mask, v;
      int nbits;
      nbits = 8 * (1 << sz);
      mask  = (64'd1 << nbits) - 64'd1;
      v     = {32'd0, w} & mask;
      if (sg && w[nbits-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic model_reset();
      exp_if_v = 1'b0;
      exp_ls_v = 1'b0;
      exp_ls_e = 1'b0;
      exp_if_d = '0;
      exp_ls_d = '0;
      last_ls  = 1'b0;
      dir_on   = 1'b0;
   endtask

   task automatic expect_ls(input logic [31:0] d, input logic e);
      dir_on = 1'b1;
      dir_d  = d;
      dir_e  = e;
   endtask

   // One clock: apply a request pair, check last cycle's responses,
   // check this cycle's grant and memory drive, then predict next cycle
   task automatic step(input logic iv, input logic [31:0] ia,
                       input logic lv, input logic [31:0] la,
                       input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd);
      logic       g_if, g_ls, wr;
      logic [3:0] ewen;
      logic [31:0] eaddr;
      @(negedge clk);
      if_req_valid = iv;
      if_addr      = ia;
      ls_req_valid = lv;
      ls_addr      = la;
      ls_we        = we;
      ls_size      = sz;
      ls_signed    = sg;
      ls_wdata     = wd;
      #1;
      chk("if_rsp_valid", if_rsp_valid, exp_if_v);
      if (exp_if_v) chk("if_rsp_data", if_rsp_data, exp_if_d);
      chk("ls_rsp_valid", ls_rsp_valid, exp_ls_v);
      if (exp_ls_v) begin
         chk("ls_rsp_data", ls_rsp_data, exp_ls_d);
         chk("ls_rsp_err", ls_rsp_err, exp_ls_e);
      end
      if (dir_on) begin
         chk("dir_ls_data", ls_rsp_data, dir_d);
         chk("dir_ls_err", ls_rsp_err, dir_e);
         dir_on = 1'b0;
      end
      if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
         g_ls = !last_ls;
`else
         g_ls = 1'b1;
`endif
         g_if = !g_ls;
      end else begin
         g_ls = lv;
         g_if = iv;
      end
      chk("if_req_ready", if_req_ready, g_if);
      chk("ls_req_ready", ls_req_ready, g_ls);
      obs_ls += int'(ls_req_ready);
      obs_if += int'(if_req_ready);
      if (!first_seen && (ls_req_ready || if_req_ready)) begin
         first_seen = 1'b1;
         first_ls   = ls_req_ready;
      end
      eaddr = g_ls ? la : (g_if ? ia : 32'd0);
      wr    = g_ls && we && (sz != 2'd3);
      ewen  = 4'hF;
      if (wr)
         for (int i = 0; i < 4; i++)
            if (i < (1 << sz)) ewen[i] = 1'b0;
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_wenableL", 32'(mem_wenableL), 32'(ewen));
      if (wr) chk("mem_data_w", mem_data_w, wd);
      exp_if_v = g_if;
      exp_ls_v = g_ls;
      if (g_if) exp_if_d = rd_word(ia);
      if (g_ls) begin
         exp_ls_e = (sz == 2'd3);
         if (we || sz == 2'd3) exp_ls_d = '0;
         else exp_ls_d = fmt_load(rd_word(la), int'(sz), sg);
      end
      if (wr)
         for (int i = 0; i < (1 << sz); i++)
            ref_mem[(la + 32'(i)) % 32'(MEMN)] = wd[8*i +: 8];
      if (g_ls || g_if) last_ls = g_ls;
      @(posedge clk);
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      obs_ls = 0;
      obs_if = 0;
      first_seen = 1'b0;
      first_ls = 1'b0;
      for (int i = 0; i < MEMN; i++) begin
         env_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      model_reset();
      rstL         = 1'b0;
      if_req_valid = 1'b1;
      if_addr      = 32'h40;
      ls_req_valid = 1'b1;
      ls_addr      = 32'h44;
      ls_we        = 1'b1;
      ls_size      = 2'd2;
      ls_signed    = 1'b0;
      ls_wdata     = 32'hFFFF_FFFF;

      // Reset state with both requesters pushing
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
      chk("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
      chk("rst_ls_rsp_err", ls_rsp_err, 1'b0);
      chk("rst_if_rsp_data", if_rsp_data, 32'd0);
      chk("rst_ls_rsp_data", ls_rsp_data, 32'd0);
      chk("rst_if_ready", if_req_ready, 1'b0);
      chk("rst_ls_ready", ls_req_ready, 1'b0);
      chk("rst_wenableL", 32'(mem_wenableL), 32'hF);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rstL = 1'b1;
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;

      // Contention: four cycles with both valid
      obs_ls = 0;
      obs_if = 0;
      first_seen = 1'b0;
      repeat (4) step(1'b1, 32'h10, 1'b1, 32'h8, 1'b0, 2'd2, 1'b0, 32'd0);
`ifdef MEM_ARB_RR_EN
      chk("cont_ls_grants", obs_ls, 32'd2);
      chk("cont_if_grants", obs_if, 32'd2);
      chk("cont_first_ls", first_ls, 1'b1);
`else
      chk("cont_ls_grants", obs_ls, 32'd4);
      chk("cont_if_grants", obs_if, 32'd0);
`endif
      idle();

      // Store word then load it back, then sub-word loads
      step(1'b0, 0, 1'b1, 32'd8, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
      expect_ls(32'd0, 1'b0);
      step(1'b0, 0, 1'b1, 32'd8, 1'b0, 2'd2, 1'b0, 32'd0);
      expect_ls(32'hDEADBEEF, 1'b0);
      step(1'b0, 0, 1'b1, 32'd11, 1'b0, 2'd0, 1'b1, 32'd0);
      expect_ls(32'hFFFFFFDE, 1'b0);
      step(1'b0, 0, 1'b1, 32'd11, 1'b0, 2'd0, 1'b0, 32'd0);
      expect_ls(32'h000000DE, 1'b0);
      step(1'b0, 0, 1'b1, 32'd10, 1'b0, 2'd1, 1'b1, 32'd0);
      expect_ls(32'hFFFFDEAD, 1'b0);

      // Illegal size store leaves memory untouched
      step(1'b0, 0, 1'b1, 32'd0, 1'b1, 2'd3, 1'b0, 32'h12345678);
      expect_ls(32'd0, 1'b1);
      step(1'b0, 0, 1'b1, 32'd0, 1'b0, 2'd2, 1'b0, 32'd0);
      expect_ls(32'd0, 1'b0);

      // Misaligned half store, word load across it
      step(1'b0, 0, 1'b1, 32'd5, 1'b1, 2'd1, 1'b0, 32'h0000ABCD);
      expect_ls(32'd0, 1'b0);
      step(1'b0, 0, 1'b1, 32'd4, 1'b0, 2'd2, 1'b0, 32'd0);
      expect_ls(32'h00ABCD00, 1'b0);
      step(1'b1, 32'd8, 1'b0, 0, 1'b0, 2'd0, 1'b0, 32'd0);
      idle();

      // Reset the cycle after a fetch grant
      step(1'b1, 32'd8, 1'b0, 0, 1'b0, 2'd0, 1'b0, 32'd0);
      @(negedge clk);
      rstL = 1'b0;
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      ls_we = 1'b1;
      ls_size = 2'd2;
      #1;
      chk("midrst_if_rsp_valid", if_rsp_valid, 1'b0);
      chk("midrst_wenableL", 32'(mem_wenableL), 32'hF);
      chk("midrst_if_ready", if_req_ready, 1'b0);
      chk("midrst_ls_ready", ls_req_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rstL = 1'b1;
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      model_reset();

      // Random traffic over a small address window
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom), 32'($urandom_range(0, 63)),
              1'($urandom), 32'($urandom_range(0, 63)),
              1'($urandom), 2'($urandom), 1'($urandom), $urandom);
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
